// File: rtl/ps2_pkg.sv
// ----------------------------------------------------------------------------
// ps2_pkg
// Shared definitions for the PS/2 keyboard receiver:
//   ps2_state_e     - frame receiver FSM states
//   PS2_EXT         - extended-code prefix byte (E0)
//   PS2_BRK         - break (release) prefix byte (F0)
//   PS2_FRAME_BITS  - bits per PS/2 frame (start + 8 data + parity + stop)
//   PS2_DATA_BITS   - data bits per frame
//   ps2_parity_ok   - odd-parity check over data byte plus parity bit
// ----------------------------------------------------------------------------
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } ps2_state_e;

    localparam logic [7:0] PS2_EXT        = 8'hE0;
    localparam logic [7:0] PS2_BRK        = 8'hF0;
    localparam int         PS2_FRAME_BITS = 11;
    localparam int         PS2_DATA_BITS  = PS2_FRAME_BITS - 3;

    // A frame is good when data plus parity carry an odd number of ones.
    function automatic logic ps2_parity_ok(input logic [7:0] data, input logic parity);
        return ^{data, parity};
    endfunction

endpackage

// File: rtl/ps2_sync_filter.sv
// ----------------------------------------------------------------------------
// ps2_sync_filter
// Brings one raw PS/2 line into the clk domain and removes glitches.
//   clk     - system clock
//   rst     - asynchronous active-low reset (line is treated as idle-high)
//   line_i  - raw asynchronous PS/2 line
//   filt_o  - synchronized line level, changes only after FILTER_LEN
//             consecutive identical samples
// ----------------------------------------------------------------------------
module ps2_sync_filter #(
    parameter int FILTER_LEN = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic line_i,
    output logic filt_o
);

    logic                  sync1_q;
    logic                  sync2_q;
    logic [FILTER_LEN-1:0] hist_q;
    logic [FILTER_LEN-1:0] hist_d;
    logic                  filt_q;
    logic                  filt_d;

    // The history window slides one synchronized sample per cycle; the
    // filtered level only moves when the whole window agrees, otherwise it
    // keeps the last accepted level.
    always_comb begin
        hist_d = FILTER_LEN'({hist_q, sync2_q});
        filt_d = filt_q;
        if (&hist_q) begin
            filt_d = 1'b1;
        end else if (~|hist_q) begin
            filt_d = 1'b0;
        end
    end

    // Two-flop synchronizer followed by the history and accepted level.
    // Everything resets to the idle-high line state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            hist_q  <= '1;
            filt_q  <= 1'b1;
        end else begin
            sync1_q <= line_i;
            sync2_q <= sync1_q;
            hist_q  <= hist_d;
            filt_q  <= filt_d;
        end
    end

    assign filt_o = filt_q;

endmodule

// File: rtl/ps2_keyboard_rx.sv
// ----------------------------------------------------------------------------
// ps2_keyboard_rx
// Receives PS/2 keyboard frames and decodes make / break / extended events.
//   clk           - system clock, the only clock in the block
//   rst           - asynchronous active-low reset
//   ps2_clk       - raw PS/2 clock line
//   ps2_data      - raw PS/2 data line
//   key_pressed   - scan code of the most recent completed key event
//   key_flag      - one-cycle pulse for a new make event
//   key_release   - one-cycle pulse for a break event
//   key_extended  - event in key_pressed carried an E0 prefix
//   frame_err     - one-cycle pulse on start/parity/stop/timeout error
// ----------------------------------------------------------------------------
module ps2_keyboard_rx
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int FILTER_LEN     = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] key_pressed,
    output logic       key_flag,
    output logic       key_release,
    output logic       key_extended,
    output logic       frame_err
);

    localparam int             TW           = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0]  TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [2:0]     LAST_BIT     = 3'(PS2_DATA_BITS - 1);

    logic          ps2ClkFilt;
    logic          ps2DataFilt;
    logic          ps2ClkPrev_q;
    logic          bitEvent;

    ps2_state_e    state_q, state_d;
    logic [2:0]    bitCnt_q, bitCnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          parity_q, parity_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          byteValid;
    logic          byteErr;

    logic          extPend_q, extPend_d;
    logic          brkPend_q, brkPend_d;
    logic          heldValid_q, heldValid_d;
    logic [7:0]    heldCode_q, heldCode_d;
    logic          heldExt_q, heldExt_d;
    logic          heldMatch;
    logic [7:0]    keyPressed_q, keyPressed_d;
    logic          keyExt_q, keyExt_d;
    logic          keyFlag_q, keyFlag_d;
    logic          keyRel_q, keyRel_d;
    logic          frameErr_q, frameErr_d;

    ps2_sync_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
        .clk    (clk),
        .rst    (rst),
        .line_i (ps2_clk),
        .filt_o (ps2ClkFilt)
    );

    ps2_sync_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filter (
        .clk    (clk),
        .rst    (rst),
        .line_i (ps2_data),
        .filt_o (ps2DataFilt)
    );

    // The keyboard drives data while its clock is high; the falling edge of
    // the filtered clock marks a stable data bit.
    assign bitEvent = ps2ClkPrev_q & ~ps2ClkFilt;

    // Frame receiver: walks start, data, parity and stop bits and flags a
    // finished byte (byteValid) or a broken frame (byteErr) for one cycle.
    // Once inside a frame, a silent clock line for TIMEOUT_CYCLES cycles
    // aborts the frame so a lost bit cannot desynchronize later frames.
    always_comb begin
        state_d   = state_q;
        bitCnt_d  = bitCnt_q;
        shift_d   = shift_q;
        parity_d  = parity_q;
        timer_d   = timer_q;
        byteValid = 1'b0;
        byteErr   = 1'b0;

        case (state_q)
            IDLE: begin
                timer_d = '0;
                if (bitEvent) begin
                    if (!ps2DataFilt) begin
                        state_d  = SHIFT;
                        bitCnt_d = '0;
                    end else begin
                        byteErr = 1'b1;
                    end
                end
            end
            SHIFT: begin
                if (bitEvent) begin
                    shift_d  = {ps2DataFilt, shift_q[7:1]};
                    bitCnt_d = bitCnt_q + 3'd1;
                    if (bitCnt_q == LAST_BIT) begin
                        state_d = PARITY;
                    end
                end
            end
            PARITY: begin
                if (bitEvent) begin
                    parity_d = ps2DataFilt;
                    state_d  = STOP;
                end
            end
            STOP: begin
                if (bitEvent) begin
                    state_d = IDLE;
                    if (ps2DataFilt && ps2_parity_ok(shift_q, parity_q)) begin
                        byteValid = 1'b1;
                    end else begin
                        byteErr = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (state_q != IDLE) begin
            if (bitEvent) begin
                timer_d = '0;
            end else if (timer_q == TIMEOUT_LAST) begin
                state_d = IDLE;
                timer_d = '0;
                byteErr = 1'b1;
            end else begin
                timer_d = timer_q + TW'(1);
            end
        end
    end

    // A make that repeats the code already held down (typematic repeat) is
    // swallowed; a matching break releases the held code.
    assign heldMatch = heldValid_q && (heldCode_q == shift_q) && (heldExt_q == extPend_q);

    // Event decoder: E0/F0 only arm prefix flags, any other byte completes
    // an event. All outputs are registered so pulses appear the cycle after
    // the stop bit. An error drops any half-received prefix sequence.
    always_comb begin
        extPend_d    = extPend_q;
        brkPend_d    = brkPend_q;
        heldValid_d  = heldValid_q;
        heldCode_d   = heldCode_q;
        heldExt_d    = heldExt_q;
        keyPressed_d = keyPressed_q;
        keyExt_d     = keyExt_q;
        keyFlag_d    = 1'b0;
        keyRel_d     = 1'b0;
        frameErr_d   = 1'b0;

        if (byteErr) begin
            frameErr_d = 1'b1;
            extPend_d  = 1'b0;
            brkPend_d  = 1'b0;
        end else if (byteValid) begin
            if (shift_q == PS2_EXT) begin
                extPend_d = 1'b1;
            end else if (shift_q == PS2_BRK) begin
                brkPend_d = 1'b1;
            end else begin
                extPend_d = 1'b0;
                brkPend_d = 1'b0;
                if (brkPend_q) begin
                    keyRel_d     = 1'b1;
                    keyPressed_d = shift_q;
                    keyExt_d     = extPend_q;
                    if (heldMatch) begin
                        heldValid_d = 1'b0;
                    end
                end else if (!heldMatch) begin
                    keyFlag_d    = 1'b1;
                    keyPressed_d = shift_q;
                    keyExt_d     = extPend_q;
                    heldValid_d  = 1'b1;
                    heldCode_d   = shift_q;
                    heldExt_d    = extPend_q;
                end
            end
        end
    end

    // State registers. Reset discards any partial frame without reporting
    // an error because frameErr_q simply resets to zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ps2ClkPrev_q <= 1'b1;
            state_q      <= IDLE;
            bitCnt_q     <= '0;
            shift_q      <= '0;
            parity_q     <= 1'b0;
            timer_q      <= '0;
            extPend_q    <= 1'b0;
            brkPend_q    <= 1'b0;
            heldValid_q  <= 1'b0;
            heldCode_q   <= '0;
            heldExt_q    <= 1'b0;
            keyPressed_q <= '0;
            keyExt_q     <= 1'b0;
            keyFlag_q    <= 1'b0;
            keyRel_q     <= 1'b0;
            frameErr_q   <= 1'b0;
        end else begin
            ps2ClkPrev_q <= ps2ClkFilt;
            state_q      <= state_d;
            bitCnt_q     <= bitCnt_d;
            shift_q      <= shift_d;
            parity_q     <= parity_d;
            timer_q      <= timer_d;
            extPend_q    <= extPend_d;
            brkPend_q    <= brkPend_d;
            heldValid_q  <= heldValid_d;
            heldCode_q   <= heldCode_d;
            heldExt_q    <= heldExt_d;
            keyPressed_q <= keyPressed_d;
            keyExt_q     <= keyExt_d;
            keyFlag_q    <= keyFlag_d;
            keyRel_q     <= keyRel_d;
            frameErr_q   <= frameErr_d;
        end
    end

    assign key_pressed  = keyPressed_q;
    assign key_extended = keyExt_q;
    assign key_flag     = keyFlag_q;
    assign key_release  = keyRel_q;
    assign frame_err    = frameErr_q;

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// ----------------------------------------------------------------------------
// tb_ps2_keyboard_rx
// Drives PS/2 frames into ps2_keyboard_rx. A reference model of the key
// decoding pushes the expected event for every frame into a queue; a monitor
// pops and compares each pulse the DUT produces.
// ----------------------------------------------------------------------------
module tb_ps2_keyboard_rx;
    import ps2_pkg::*;

    localparam int HALF = 20;

    localparam logic [2:0] K_MAKE = 3'b001;
    localparam logic [2:0] K_REL  = 3'b010;
    localparam logic [2:0] K_ERR  = 3'b100;

    typedef struct packed {
        logic [2:0] kind;
        logic [7:0] code;
        logic       ext;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       ps2_clk;
    logic       ps2_data;
    logic [7:0] key_pressed;
    logic       key_flag;
    logic       key_release;
    logic       key_extended;
    logic       frame_err;

    int   compared   = 0;
    int   mismatched = 0;
    int   cycleCnt   = 0;
    int   lastFallCycle = 0;
    int   errDelta   = 0;
    logic gotErr     = 1'b0;

    exp_t expQ[$];

    logic [7:0] mKey;
    logic       mExt;
    logic       mExtPend;
    logic       mBrkPend;
    logic       mHeldValid;
    logic [7:0] mHeldCode;
    logic       mHeldExt;

    ps2_keyboard_rx #(
        .TIMEOUT_CYCLES (100),
        .FILTER_LEN     (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .ps2_clk      (ps2_clk),
        .ps2_data     (ps2_data),
        .key_pressed  (key_pressed),
        .key_flag     (key_flag),
        .key_release  (key_release),
        .key_extended (key_extended),
        .frame_err    (frame_err)
    );

    // 100 MHz system clock and a free-running cycle counter.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Reference model of the key decoder, fed one received byte at a time.
    task automatic modelReset();
        mKey = 8'h00; mExt = 1'b0; mExtPend = 1'b0; mBrkPend = 1'b0;
        mHeldValid = 1'b0; mHeldCode = 8'h00; mHeldExt = 1'b0;
    endtask

    task automatic modelErr();
        expQ.push_back('{kind: K_ERR, code: mKey, ext: mExt});
        mExtPend = 1'b0;
        mBrkPend = 1'b0;
    endtask

    task automatic modelByte(input logic [7:0] b);
        logic same;
        if (b == 8'hE0) begin
            mExtPend = 1'b1;
        end else if (b == 8'hF0) begin
            mBrkPend = 1'b1;
        end else begin
            same = mHeldValid && (mHeldCode == b) && (mHeldExt == mExtPend);
            if (mBrkPend) begin
                mKey = b; mExt = mExtPend;
                expQ.push_back('{kind: K_REL, code: b, ext: mExtPend});
                if (same) mHeldValid = 1'b0;
            end else if (!same) begin
                mKey = b; mExt = mExtPend;
                expQ.push_back('{kind: K_MAKE, code: b, ext: mExtPend});
                mHeldValid = 1'b1; mHeldCode = b; mHeldExt = mExtPend;
            end
            mExtPend = 1'b0;
            mBrkPend = 1'b0;
        end
    endtask

    // One PS/2 bit: data set up while clock high, then a clock low phase.
    task automatic ps2Bit(input logic b);
        @(negedge clk);
        ps2_data = b;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b0;
        lastFallCycle = cycleCnt;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b1;
    endtask

    // Full frame with optional parity or stop corruption; the model is
    // updated before the bits go out.
    task automatic applyStimulus(input logic [7:0] b, input logic badParity, input logic badStop);
        if (badParity || badStop) modelErr();
        else modelByte(b);
        ps2Bit(1'b0);
        for (int i = 0; i < 8; i++) ps2Bit(b[i]);
        ps2Bit((~^b) ^ badParity);
        ps2Bit(~badStop);
        ps2_data = 1'b1;
        repeat (3 * HALF) @(negedge clk);
    endtask

    task automatic sendPartial(input int nBits);
        ps2Bit(1'b0);
        for (int i = 1; i < nBits; i++) ps2Bit(i[0]);
        ps2_data = 1'b1;
    endtask

    // Scoreboard monitor: every pulse must match the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rst && (key_flag || key_release || frame_err)) begin
            if (frame_err) begin
                gotErr   = 1'b1;
                errDelta = cycleCnt - lastFallCycle;
            end
            if (expQ.size() == 0) begin
                checkOutput("unexpected_pulse", {29'd0, frame_err, key_release, key_flag}, 32'd0);
            end else begin
                e = expQ.pop_front();
                checkOutput("event_kind", {29'd0, frame_err, key_release, key_flag}, {29'd0, e.kind});
                checkOutput("key_pressed", {24'd0, key_pressed}, {24'd0, e.code});
                checkOutput("key_extended", {31'd0, key_extended}, {31'd0, e.ext});
            end
        end
    end

    initial begin
        rst      = 1'b0;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        modelReset();
        repeat (5) @(negedge clk);
        checkOutput("rst_key_pressed", {24'd0, key_pressed}, 32'd0);
        checkOutput("rst_key_flag", {31'd0, key_flag}, 32'd0);
        checkOutput("rst_key_release", {31'd0, key_release}, 32'd0);
        checkOutput("rst_key_extended", {31'd0, key_extended}, 32'd0);
        checkOutput("rst_frame_err", {31'd0, frame_err}, 32'd0);
        rst = 1'b1;
        repeat (10) @(negedge clk);

        $display("[TB] basic make / break / extended");
        applyStimulus(8'h16, 1'b0, 1'b0);
        applyStimulus(8'hF0, 1'b0, 1'b0);
        applyStimulus(8'h16, 1'b0, 1'b0);
        applyStimulus(8'hE0, 1'b0, 1'b0);
        applyStimulus(8'h75, 1'b0, 1'b0);
        applyStimulus(8'hE0, 1'b0, 1'b0);
        applyStimulus(8'hF0, 1'b0, 1'b0);
        applyStimulus(8'h75, 1'b0, 1'b0);

        $display("[TB] error frames");
        applyStimulus(8'h15, 1'b1, 1'b0);
        applyStimulus(8'h22, 1'b0, 1'b1);
        modelErr();
        ps2Bit(1'b1);
        repeat (3 * HALF) @(negedge clk);
        applyStimulus(8'hE0, 1'b0, 1'b0);
        applyStimulus(8'h33, 1'b1, 1'b0);
        applyStimulus(8'h74, 1'b0, 1'b0);

        $display("[TB] typematic repeat and non-matching break");
        for (int i = 0; i < 3; i++) applyStimulus(8'h16, 1'b0, 1'b0);
        applyStimulus(8'hF0, 1'b0, 1'b0);
        applyStimulus(8'h1C, 1'b0, 1'b0);
        applyStimulus(8'h16, 1'b0, 1'b0);
        applyStimulus(8'hE0, 1'b0, 1'b0);
        applyStimulus(8'h16, 1'b0, 1'b0);

        $display("[TB] timeout");
        gotErr = 1'b0;
        modelErr();
        sendPartial(4);
        for (int i = 0; i < 300 && !gotErr; i++) @(negedge clk);
        checkOutput("timeout_fired", {31'd0, gotErr}, 32'd1);
        checkOutput("timeout_window", {31'd0, (errDelta >= 100) && (errDelta <= 120)}, 32'd1);
        checkOutput("timeout_fsm_idle", {30'd0, dut.state_q}, {30'd0, IDLE});
        repeat (2 * HALF) @(negedge clk);

        $display("[TB] reset mid-frame");
        sendPartial(5);
        @(negedge clk);
        rst = 1'b0;
        modelReset();
        repeat (5) @(negedge clk);
        rst = 1'b1;
        repeat (10) @(negedge clk);
        checkOutput("midrst_key_pressed", {24'd0, key_pressed}, 32'd0);
        applyStimulus(8'h15, 1'b0, 1'b0);

        repeat (4 * HALF) @(negedge clk);
        checkOutput("queue_drained", expQ.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
